// File: rtl/tmds_pkg.sv
// Shared types and constants for the TMDS PLL sequencer.
// The package holds the FSM encoding, the phase/duty field width, their defaults and a max helper.
package tmds_pkg;

  typedef enum logic [2:0] {
    RST_HOLD,
    WAIT_LOCK,
    LOCK_FILT,
    RUN,
    SETTLE
  } pll_state_t;

  localparam int CFG_W = 4;
  localparam logic [CFG_W-1:0] DEF_PSDA_C   = 4'b0000;
  localparam logic [CFG_W-1:0] DEF_DUTYDA_C = 4'b1000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer for slow asynchronous status inputs.
// The output resets to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/tmds_pll_ctrl.sv
// TMDS serial-clock PLL sequencer.
// The block pulses the PLL reset and qualifies LOCK before releasing the serializer. It also applies PSDA/DUTYDA updates.
module tmds_pll_ctrl
  import tmds_pkg::*;
#(
  parameter int              RST_CYCLES    = 16,
  parameter int              LOCK_TIMEOUT  = 65536,
  parameter int              STABLE_CYCLES = 1024,
  parameter int              SETTLE_CYCLES = 64,
  parameter int              MAX_RETRY     = 4,
  parameter logic [CFG_W-1:0] DEF_PSDA     = DEF_PSDA_C,
  parameter logic [CFG_W-1:0] DEF_DUTYDA   = DEF_DUTYDA_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock_i,
  output logic             pll_reset_o,
  output logic [CFG_W-1:0] pll_psda_o,
  output logic [CFG_W-1:0] pll_dutyda_o,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_psda,
  input  logic [CFG_W-1:0] cfg_dutyda,
  output logic             cfg_ready,
  output logic             serdes_rst_n_o,
  output logic             pll_ready,
  output logic             pll_fail,
  output logic [7:0]       relock_cnt
);

  localparam int TMAX    = max_int(max_int(RST_CYCLES, LOCK_TIMEOUT),
                                   max_int(STABLE_CYCLES, SETTLE_CYCLES));
  localparam int TIMER_W = max_int($clog2(TMAX + 1), 1);
  localparam int RETRY_W = max_int($clog2(MAX_RETRY + 1), 1);

  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LAST     = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  pll_state_t         state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic               fail_reg, fail_next;
  logic [7:0]         relock_reg, relock_next;
  logic [CFG_W-1:0]   psda_reg, psda_next;
  logic [CFG_W-1:0]   dutyda_reg, dutyda_next;
  logic               pll_reset_reg, serdes_rst_n_reg, ready_reg;
  logic               lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock_i),
    .q     (lock_s)
  );

  // A lock drop in RUN always wins over a pending update.
  assign cfg_ready = (state_reg == RUN) && lock_s;

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg + TIMER_ONE;
    retry_next  = retry_reg;
    fail_next   = fail_reg;
    relock_next = relock_reg;
    psda_next   = psda_reg;
    dutyda_next = dutyda_reg;

    case (state_reg)
      RST_HOLD: begin
        if (timer_reg == RST_LAST) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next = LOCK_FILT;
        end else if (timer_reg == TO_LAST) begin
          if (retry_reg != RETRY_MAX) retry_next = retry_reg + 1'b1;
          if (retry_next == RETRY_MAX) fail_next = 1'b1;
          state_next = RST_HOLD;
        end
      end
      LOCK_FILT: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
        end else if (timer_reg == STABLE_LAST) begin
          state_next = RUN;
          retry_next = '0;
          fail_next  = 1'b0;
        end
      end
      RUN: begin
        timer_next = '0;
        if (!lock_s) begin
          if (relock_reg != 8'hFF) relock_next = relock_reg + 8'd1;
          state_next = RST_HOLD;
        end else if (cfg_valid) begin
          psda_next   = cfg_psda;
          dutyda_next = cfg_dutyda;
          state_next  = SETTLE;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          if (relock_reg != 8'hFF) relock_next = relock_reg + 8'd1;
          state_next = RST_HOLD;
        end else if (timer_reg == SETTLE_LAST) begin
          state_next = RUN;
        end
      end
      default: state_next = RST_HOLD;
    endcase

    // Every state entry restarts the shared timer.
    if (state_next != state_reg) timer_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= RST_HOLD;
      timer_reg        <= '0;
      retry_reg        <= '0;
      fail_reg         <= 1'b0;
      relock_reg       <= 8'd0;
      psda_reg         <= DEF_PSDA;
      dutyda_reg       <= DEF_DUTYDA;
      pll_reset_reg    <= 1'b1;
      serdes_rst_n_reg <= 1'b0;
      ready_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      timer_reg        <= timer_next;
      retry_reg        <= retry_next;
      fail_reg         <= fail_next;
      relock_reg       <= relock_next;
      psda_reg         <= psda_next;
      dutyda_reg       <= dutyda_next;
      pll_reset_reg    <= (state_next == RST_HOLD);
      serdes_rst_n_reg <= (state_next == RUN);
      ready_reg        <= (state_next == RUN);
    end
  end

  assign pll_reset_o    = pll_reset_reg;
  assign pll_psda_o     = psda_reg;
  assign pll_dutyda_o   = dutyda_reg;
  assign serdes_rst_n_o = serdes_rst_n_reg;
  assign pll_ready      = ready_reg;
  assign pll_fail       = fail_reg;
  assign relock_cnt     = relock_reg;

endmodule

// File: tb/tb_tmds_pll_ctrl.sv
// Directed bench for tmds_pll_ctrl with short timing parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tmds_pll_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock_i = 1'b0;
  logic       pll_reset_o;
  logic [3:0] pll_psda_o;
  logic [3:0] pll_dutyda_o;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_psda = 4'h0;
  logic [3:0] cfg_dutyda = 4'h0;
  logic       cfg_ready;
  logic       serdes_rst_n_o;
  logic       pll_ready;
  logic       pll_fail;
  logic [7:0] relock_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tmds_pll_ctrl #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .SETTLE_CYCLES (4),
    .MAX_RETRY     (2),
    .DEF_PSDA      (4'b0000),
    .DEF_DUTYDA    (4'b1000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pll_lock_i     (pll_lock_i),
    .pll_reset_o    (pll_reset_o),
    .pll_psda_o     (pll_psda_o),
    .pll_dutyda_o   (pll_dutyda_o),
    .cfg_valid      (cfg_valid),
    .cfg_psda       (cfg_psda),
    .cfg_dutyda     (cfg_dutyda),
    .cfg_ready      (cfg_ready),
    .serdes_rst_n_o (serdes_rst_n_o),
    .pll_ready      (pll_ready),
    .pll_fail       (pll_fail),
    .relock_cnt     (relock_cnt)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench on the falling edge where rst_n is released (cycle 0).
  task automatic apply_reset();
    rst_n = 1'b0;
    pll_lock_i = 1'b0;
    cfg_valid = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL rst_pll_reset got %b want 1", pll_reset_o); end
    n_cmp++; if (pll_psda_o !== 4'b0000) begin n_bad++; $display("FAIL rst_psda got %b want 0000", pll_psda_o); end
    n_cmp++; if (pll_dutyda_o !== 4'b1000) begin n_bad++; $display("FAIL rst_dutyda got %b want 1000", pll_dutyda_o); end
    n_cmp++; if (serdes_rst_n_o !== 1'b0) begin n_bad++; $display("FAIL rst_serdes got %b want 0", serdes_rst_n_o); end
    n_cmp++; if (pll_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", pll_ready); end
    n_cmp++; if (pll_fail !== 1'b0) begin n_bad++; $display("FAIL rst_fail got %b want 0", pll_fail); end
    n_cmp++; if (relock_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_relock got %0d want 0", relock_cnt); end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cfg_ready got %b want 0", cfg_ready); end
    $display("reset: checked reset values");
  endtask

  task automatic test_lock_up();
    apply_reset();
    n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL up_pll_reset c0 got %b want 1", pll_reset_o); end
    for (int k = 1; k <= 3; k++) begin
      step(1);
      n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL up_pll_reset c%0d got %b want 1", k, pll_reset_o); end
    end
    step(1);
    n_cmp++; if (pll_reset_o !== 1'b0) begin n_bad++; $display("FAIL up_pll_reset c4 got %b want 0", pll_reset_o); end
    step(6);
    pll_lock_i = 1'b1;
    step(10);
    n_cmp++; if (pll_ready !== 1'b0) begin n_bad++; $display("FAIL up_ready_early c20 got %b want 0", pll_ready); end
    n_cmp++; if (serdes_rst_n_o !== 1'b0) begin n_bad++; $display("FAIL up_serdes_early c20 got %b want 0", serdes_rst_n_o); end
    step(1);
    n_cmp++; if (pll_ready !== 1'b1) begin n_bad++; $display("FAIL up_ready c21 got %b want 1", pll_ready); end
    n_cmp++; if (serdes_rst_n_o !== 1'b1) begin n_bad++; $display("FAIL up_serdes c21 got %b want 1", serdes_rst_n_o); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL up_cfg_ready got %b want 1", cfg_ready); end
    n_cmp++; if (pll_psda_o !== 4'b0000) begin n_bad++; $display("FAIL up_psda got %b want 0000", pll_psda_o); end
    n_cmp++; if (pll_dutyda_o !== 4'b1000) begin n_bad++; $display("FAIL up_dutyda got %b want 1000", pll_dutyda_o); end
    $display("lock_up: RUN reached at cycle 21");
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    step(35);
    n_cmp++; if (pll_reset_o !== 1'b0) begin n_bad++; $display("FAIL to_reset c35 got %b want 0", pll_reset_o); end
    step(1);
    n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL to_reset c36 got %b want 1", pll_reset_o); end
    step(4);
    n_cmp++; if (pll_reset_o !== 1'b0) begin n_bad++; $display("FAIL to_reset c40 got %b want 0", pll_reset_o); end
    step(31);
    n_cmp++; if (pll_fail !== 1'b0) begin n_bad++; $display("FAIL to_fail c71 got %b want 0", pll_fail); end
    step(1);
    n_cmp++; if (pll_fail !== 1'b1) begin n_bad++; $display("FAIL to_fail c72 got %b want 1", pll_fail); end
    n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL to_reset c72 got %b want 1", pll_reset_o); end
    step(8);
    n_cmp++; if (pll_fail !== 1'b1) begin n_bad++; $display("FAIL to_fail_sticky c80 got %b want 1", pll_fail); end
    pll_lock_i = 1'b1;
    n = 0;
    while (pll_ready !== 1'b1 && n < 100) begin step(1); n++; end
    n_cmp++; if (pll_ready !== 1'b1) begin n_bad++; $display("FAIL to_relock_timeout got %b want 1", pll_ready); end
    n_cmp++; if (pll_fail !== 1'b0) begin n_bad++; $display("FAIL to_fail_clear got %b want 0", pll_fail); end
    $display("timeout: two timeouts then lock after %0d cycles", n);
  endtask

  task automatic test_glitch();
    apply_reset();
    step(10);
    pll_lock_i = 1'b1;
    step(5);
    pll_lock_i = 1'b0;
    step(1);
    pll_lock_i = 1'b1;
    for (int k = 17; k <= 26; k++) begin
      step(1);
      n_cmp++; if (pll_ready !== 1'b0) begin n_bad++; $display("FAIL gl_ready c%0d got %b want 0", k, pll_ready); end
      n_cmp++; if (pll_reset_o !== 1'b0) begin n_bad++; $display("FAIL gl_pll_reset c%0d got %b want 0", k, pll_reset_o); end
    end
    step(1);
    n_cmp++; if (pll_ready !== 1'b1) begin n_bad++; $display("FAIL gl_ready c27 got %b want 1", pll_ready); end
    $display("glitch: filter restarted, RUN at cycle 27");
  endtask

  task automatic test_cfg_update();
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL cfg_ready_pre got %b want 1", cfg_ready); end
    cfg_valid = 1'b1;
    cfg_psda = 4'b0101;
    cfg_dutyda = 4'b0110;
    step(1);
    cfg_valid = 1'b0;
    $display("cfg write psda=0101 dutyda=0110");
    n_cmp++; if (pll_psda_o !== 4'b0101) begin n_bad++; $display("FAIL cfg_psda got %b want 0101", pll_psda_o); end
    n_cmp++; if (pll_dutyda_o !== 4'b0110) begin n_bad++; $display("FAIL cfg_dutyda got %b want 0110", pll_dutyda_o); end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL cfg_ready_settle got %b want 0", cfg_ready); end
    n_cmp++; if (pll_ready !== 1'b0) begin n_bad++; $display("FAIL cfg_ready_drop got %b want 0", pll_ready); end
    n_cmp++; if (serdes_rst_n_o !== 1'b0) begin n_bad++; $display("FAIL cfg_serdes s0 got %b want 0", serdes_rst_n_o); end
    for (int k = 1; k <= 3; k++) begin
      step(1);
      n_cmp++; if (serdes_rst_n_o !== 1'b0) begin n_bad++; $display("FAIL cfg_serdes s%0d got %b want 0", k, serdes_rst_n_o); end
    end
    step(1);
    n_cmp++; if (serdes_rst_n_o !== 1'b1) begin n_bad++; $display("FAIL cfg_serdes s4 got %b want 1", serdes_rst_n_o); end
    n_cmp++; if (pll_ready !== 1'b1) begin n_bad++; $display("FAIL cfg_ready_back got %b want 1", pll_ready); end
  endtask

  task automatic test_lock_loss();
    int n;
    pll_lock_i = 1'b0;
    step(2);
    n_cmp++; if (serdes_rst_n_o !== 1'b1) begin n_bad++; $display("FAIL ll_serdes f2 got %b want 1", serdes_rst_n_o); end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL ll_cfg_ready f2 got %b want 0", cfg_ready); end
    step(1);
    n_cmp++; if (serdes_rst_n_o !== 1'b0) begin n_bad++; $display("FAIL ll_serdes f3 got %b want 0", serdes_rst_n_o); end
    n_cmp++; if (relock_cnt !== 8'd1) begin n_bad++; $display("FAIL ll_relock got %0d want 1", relock_cnt); end
    n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL ll_pll_reset got %b want 1", pll_reset_o); end
    pll_lock_i = 1'b1;
    n = 0;
    while (pll_ready !== 1'b1 && n < 100) begin step(1); n++; end
    n_cmp++; if (pll_ready !== 1'b1) begin n_bad++; $display("FAIL ll_relock_timeout got %b want 1", pll_ready); end
    n_cmp++; if (pll_psda_o !== 4'b0101) begin n_bad++; $display("FAIL ll_psda_kept got %b want 0101", pll_psda_o); end
    n_cmp++; if (pll_dutyda_o !== 4'b0110) begin n_bad++; $display("FAIL ll_dutyda_kept got %b want 0110", pll_dutyda_o); end
    $display("lock_loss: relocked after %0d cycles", n);
  endtask

  task automatic test_back_to_back();
    int n;
    int total;
    pll_lock_i = 1'b0;
    step(2);
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL bb_cfg_ready got %b want 0", cfg_ready); end
    cfg_valid = 1'b1;
    cfg_psda = 4'b1111;
    cfg_dutyda = 4'b0011;
    step(1);
    cfg_valid = 1'b0;
    n_cmp++; if (pll_psda_o !== 4'b0101) begin n_bad++; $display("FAIL bb_psda got %b want 0101", pll_psda_o); end
    n_cmp++; if (pll_dutyda_o !== 4'b0110) begin n_bad++; $display("FAIL bb_dutyda got %b want 0110", pll_dutyda_o); end
    n_cmp++; if (relock_cnt !== 8'd2) begin n_bad++; $display("FAIL bb_relock got %0d want 2", relock_cnt); end
    pll_lock_i = 1'b1;
    total = 2;
    for (int i = 0; i < 298; i++) begin
      n = 0;
      while (pll_ready !== 1'b1 && n < 100) begin step(1); n++; end
      n_cmp++;
      if (pll_ready !== 1'b1) begin
        n_bad++; $display("FAIL sat_wait_ready loss %0d got %b want 1", total, pll_ready);
        break;
      end
      pll_lock_i = 1'b0;
      step(1);
      pll_lock_i = 1'b1;
      n = 0;
      while (pll_ready !== 1'b0 && n < 10) begin step(1); n++; end
      total++;
      if (total == 100) begin
        n_cmp++; if (relock_cnt !== 8'd100) begin n_bad++; $display("FAIL sat_relock100 got %0d want 100", relock_cnt); end
      end
    end
    n = 0;
    while (pll_ready !== 1'b1 && n < 100) begin step(1); n++; end
    n_cmp++; if (relock_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_relock got %0d want 255", relock_cnt); end
    $display("back_to_back: %0d lock losses, relock_cnt=%0d", total, relock_cnt);
  endtask

  task automatic test_midop_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pll_psda_o !== 4'b0000) begin n_bad++; $display("FAIL mr_psda got %b want 0000", pll_psda_o); end
    n_cmp++; if (pll_dutyda_o !== 4'b1000) begin n_bad++; $display("FAIL mr_dutyda got %b want 1000", pll_dutyda_o); end
    n_cmp++; if (relock_cnt !== 8'd0) begin n_bad++; $display("FAIL mr_relock got %0d want 0", relock_cnt); end
    n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL mr_pll_reset got %b want 1", pll_reset_o); end
    n_cmp++; if (serdes_rst_n_o !== 1'b0) begin n_bad++; $display("FAIL mr_serdes got %b want 0", serdes_rst_n_o); end
    n_cmp++; if (pll_ready !== 1'b0) begin n_bad++; $display("FAIL mr_ready got %b want 0", pll_ready); end
    $display("midop_reset: async reset from RUN");
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_timeout();
    test_glitch();
    test_cfg_update();
    test_lock_loss();
    test_back_to_back();
    test_midop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
